// File: rtl/operand_extend_stage.sv
// Operand half of the ID/EX pipeline register: ARMv8 immediate extension,
// operand-B forwarding and selection, held in a stallable/flushable register.
module operand_extend_stage #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             stall,
   input  logic             flush,
   input  logic [WIDTH-1:0] d2,
   input  logic [25:0]      instr_imm,
   input  logic [2:0]       imm_sel,
   input  logic             alu_src,
   input  logic [1:0]       fwd_sel,
   input  logic [WIDTH-1:0] fwd_exmem,
   input  logic [WIDTH-1:0] fwd_memwb,
   output logic             out_valid,
   output logic [WIDTH-1:0] alu_b,
   output logic [WIDTH-1:0] mem_data,
   output logic [WIDTH-1:0] imm_out,
   output logic [CNT_W-1:0] bubble_count
);

   localparam logic [2:0] SEL_IMM12 = 3'd0;
   localparam logic [2:0] SEL_IMM9  = 3'd1;
   localparam logic [2:0] SEL_CB19  = 3'd2;
   localparam logic [2:0] SEL_B26   = 3'd3;
   localparam logic [2:0] SEL_MOVZ  = 3'd4;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] imm12_ext, imm9_ext, cb19_ext, b26_ext;
   logic [WIDTH-1:0] movz_base, movz_ext;
   logic [5:0]       movz_shamt;
   logic [WIDTH-1:0] imm_d, fwd_d, alu_b_d;
   logic             bubble_inc;
   logic [CNT_W-1:0] bubble_sat_d;

   logic             out_valid_q;
   logic [WIDTH-1:0] alu_b_q, mem_data_q, imm_out_q;
   logic [CNT_W-1:0] bubble_count_q;

   assign imm12_ext = {{(WIDTH-12){1'b0}}, instr_imm[21:10]};
   assign imm9_ext  = {{(WIDTH-9){instr_imm[20]}}, instr_imm[20:12]};
   assign cb19_ext  = {{(WIDTH-21){instr_imm[23]}}, instr_imm[23:5], 2'b00};
   assign b26_ext   = {{(WIDTH-28){instr_imm[25]}}, instr_imm[25:0], 2'b00};

   // Shifts of WIDTH or more yield zero, so hw>=2 at WIDTH=32 drops the constant.
   assign movz_base  = {{(WIDTH-16){1'b0}}, instr_imm[20:5]};
   assign movz_shamt = {instr_imm[22:21], 4'b0000};
   assign movz_ext   = movz_base << movz_shamt;

   always_comb begin
      imm_d = '0;
      case (imm_sel)
         SEL_IMM12: imm_d = imm12_ext;
         SEL_IMM9:  imm_d = imm9_ext;
         SEL_CB19:  imm_d = cb19_ext;
         SEL_B26:   imm_d = b26_ext;
         SEL_MOVZ:  imm_d = movz_ext;
         default:   imm_d = '0;
      endcase
   end

   always_comb begin
      fwd_d = d2;
      case (fwd_sel)
         2'b01:   fwd_d = fwd_exmem;
         2'b10:   fwd_d = fwd_memwb;
         default: fwd_d = d2;
      endcase
   end

   assign alu_b_d = alu_src ? imm_d : fwd_d;

   // A bubble is either a flush or an unstalled load of an invalid slot.
   assign bubble_inc   = flush | (~stall & ~in_valid);
   assign bubble_sat_d = (bubble_inc && bubble_count_q != CNT_MAX) ?
                         bubble_count_q + CNT_W'(1) : bubble_count_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q    <= 1'b0;
         alu_b_q        <= '0;
         mem_data_q     <= '0;
         imm_out_q      <= '0;
         bubble_count_q <= '0;
      end else if (flush) begin
         out_valid_q    <= 1'b0;
         alu_b_q        <= '0;
         mem_data_q     <= '0;
         imm_out_q      <= '0;
         bubble_count_q <= bubble_sat_d;
      end else if (!stall) begin
         out_valid_q    <= in_valid;
         alu_b_q        <= alu_b_d;
         mem_data_q     <= fwd_d;
         imm_out_q      <= imm_d;
         bubble_count_q <= bubble_sat_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign alu_b        = alu_b_q;
   assign mem_data     = mem_data_q;
   assign imm_out      = imm_out_q;
   assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_operand_extend_stage.sv
// Directed bench: a 64-bit/16-bit-counter instance and a 32-bit/4-bit-counter
// instance share stimulus and are checked against hand-computed values.
module tb_operand_extend_stage;

   logic        clk;
   logic        reset;
   logic        in_valid, stall, flush, alu_src;
   logic [63:0] d2, fwd_exmem, fwd_memwb;
   logic [25:0] instr_imm;
   logic [2:0]  imm_sel;
   logic [1:0]  fwd_sel;

   logic        ov64, ov32;
   logic [63:0] alu_b64, mem64, imm64;
   logic [31:0] alu_b32, mem32, imm32;
   logic [15:0] bc64;
   logic [3:0]  bc32;

   int checks;
   int failures;

   operand_extend_stage #(.WIDTH(64), .CNT_W(16)) dut64 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
      .d2(d2), .instr_imm(instr_imm), .imm_sel(imm_sel), .alu_src(alu_src),
      .fwd_sel(fwd_sel), .fwd_exmem(fwd_exmem), .fwd_memwb(fwd_memwb),
      .out_valid(ov64), .alu_b(alu_b64), .mem_data(mem64), .imm_out(imm64),
      .bubble_count(bc64)
   );

   operand_extend_stage #(.WIDTH(32), .CNT_W(4)) dut32 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
      .d2(d2[31:0]), .instr_imm(instr_imm), .imm_sel(imm_sel), .alu_src(alu_src),
      .fwd_sel(fwd_sel), .fwd_exmem(fwd_exmem[31:0]), .fwd_memwb(fwd_memwb[31:0]),
      .out_valid(ov32), .alu_b(alu_b32), .mem_data(mem32), .imm_out(imm32),
      .bubble_count(bc32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " ov64"},  {63'd0, ov64}, 64'd0);
      check({tag, " alu64"}, alu_b64, 64'd0);
      check({tag, " mem64"}, mem64, 64'd0);
      check({tag, " imm64"}, imm64, 64'd0);
      check({tag, " bc64"},  {48'd0, bc64}, 64'd0);
      check({tag, " ov32"},  {63'd0, ov32}, 64'd0);
      check({tag, " bc32"},  {60'd0, bc32}, 64'd0);
   endtask

   logic [63:0] fwd_exp [4];
   logic [3:0]  sat_exp;

   initial begin
      checks = 0;
      failures = 0;
      fwd_exp[0] = 64'd5; fwd_exp[1] = 64'd7; fwd_exp[2] = 64'd9; fwd_exp[3] = 64'd5;

      // Reset held while the inputs request a valid load.
      reset = 1'b1; in_valid = 1'b1; stall = 1'b0; flush = 1'b0; alu_src = 1'b1;
      d2 = 64'h55; fwd_exmem = 64'h77; fwd_memwb = 64'h99;
      instr_imm = 26'h3FFFFFF; imm_sel = 3'd3; fwd_sel = 2'b00;
      tick(); tick();
      check_all_zero("reset_hold");

      reset = 1'b0;
      d2 = 64'd0; imm_sel = 3'd0; instr_imm = 26'(12'h001) << 10;
      tick();
      check("first_load ov", {63'd0, ov64}, 64'd1);
      check("first_load alu_b", alu_b64, 64'd1);
      check("first_load imm", imm64, 64'd1);
      check("first_load mem", mem64, 64'd0);
      check("first_load bc", {48'd0, bc64}, 64'd0);

      imm_sel = 3'd1; instr_imm = 26'(9'h1FE) << 12;
      tick();
      check("imm9 64", imm64, 64'hFFFF_FFFF_FFFF_FFFE);
      check("imm9 32", {32'd0, imm32}, 64'h0000_0000_FFFF_FFFE);

      imm_sel = 3'd2; instr_imm = 26'(19'h7FFFF) << 5;
      tick();
      check("cb19 64", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
      check("cb19 32", {32'd0, imm32}, 64'h0000_0000_FFFF_FFFC);
      check("cb19 alu_b", alu_b64, 64'hFFFF_FFFF_FFFF_FFFC);

      imm_sel = 3'd3; instr_imm = 26'h0000001;
      tick();
      check("b26 64", imm64, 64'd4);
      check("b26 32", {32'd0, imm32}, 64'd4);

      imm_sel = 3'd4; instr_imm = (26'd3 << 21) | (26'(16'hABCD) << 5);
      tick();
      check("movz hw3 64", imm64, 64'hABCD_0000_0000_0000);
      check("movz hw3 32", {32'd0, imm32}, 64'd0);

      instr_imm = (26'd1 << 21) | (26'(16'hABCD) << 5);
      tick();
      check("movz hw1 64", imm64, 64'h0000_0000_ABCD_0000);
      check("movz hw1 32", {32'd0, imm32}, 64'h0000_0000_ABCD_0000);

      imm_sel = 3'd5;
      tick();
      check("reserved imm", imm64, 64'd0);
      check("reserved alu_b", alu_b64, 64'd0);

      // Forwarding sweep with the register path selected.
      d2 = 64'd5; fwd_exmem = 64'd7; fwd_memwb = 64'd9; alu_src = 1'b0;
      for (int s = 0; s < 4; s++) begin
         fwd_sel = 2'(s);
         tick();
         check($sformatf("fwd%0d alu_b", s), alu_b64, fwd_exp[s]);
         check($sformatf("fwd%0d mem", s), mem64, fwd_exp[s]);
      end

      alu_src = 1'b1; imm_sel = 3'd0; instr_imm = 26'(12'h003) << 10; fwd_sel = 2'b01;
      tick();
      check("imm_sel_b alu_b", alu_b64, 64'd3);
      check("imm_sel_b mem exmem", mem64, 64'd7);
      fwd_sel = 2'b10;
      tick();
      check("imm_sel_b mem memwb", mem64, 64'd9);

      // Load a value then stall three cycles with every input changing.
      alu_src = 1'b0; fwd_sel = 2'b00; d2 = 64'h1234;
      tick();
      check("pre_stall alu_b", alu_b64, 64'h1234);
      stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b0; d2 = 64'hDEAD_0000 + 64'(c); fwd_sel = 2'(c + 1);
         fwd_exmem = 64'hBEEF; alu_src = c[0]; imm_sel = 3'(c); instr_imm = 26'h2AAAAAA;
         tick();
         check($sformatf("stall%0d ov", c), {63'd0, ov64}, 64'd1);
         check($sformatf("stall%0d alu_b", c), alu_b64, 64'h1234);
         check($sformatf("stall%0d mem", c), mem64, 64'h1234);
         check($sformatf("stall%0d imm", c), imm64, 64'd3);
         check($sformatf("stall%0d bc", c), {48'd0, bc64}, 64'd0);
      end

      flush = 1'b1;
      tick();
      check("flush ov", {63'd0, ov64}, 64'd0);
      check("flush alu_b", alu_b64, 64'd0);
      check("flush mem", mem64, 64'd0);
      check("flush imm", imm64, 64'd0);
      check("flush bc64", {48'd0, bc64}, 64'd1);
      check("flush bc32", {60'd0, bc32}, 64'd1);

      // Twenty bubble loads on top of the one flush bubble.
      flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
      for (int b = 0; b < 20; b++) begin
         tick();
         sat_exp = (b + 2 > 15) ? 4'd15 : 4'(b + 2);
         check($sformatf("sat%0d bc32", b), {60'd0, bc32}, {60'd0, sat_exp});
      end
      check("sat bc64", {48'd0, bc64}, 64'd21);
      check("sat ov", {63'd0, ov64}, 64'd0);

      tick();
      #2;
      reset = 1'b1;
      #1;
      check_all_zero("async_reset");
      @(negedge clk);
      reset = 1'b0;

      in_valid = 1'b1; alu_src = 1'b1; imm_sel = 3'd0; instr_imm = 26'(12'h0FF) << 10;
      tick();
      check("post_reset ov", {63'd0, ov64}, 64'd1);
      check("post_reset alu_b", alu_b64, 64'h0FF);
      check("post_reset bc32", {60'd0, bc32}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
